io_port_bank: RTL
=================

# io_port_bank

Parametrised memory-mapped I/O port bank: NUM_PORTS input ports and NUM_PORTS output ports of DATA_WIDTH bits each, mapped into a contiguous window at the top of the data address space. Input pins pass through a two-flop synchronizer. Per-port change detection feeds a sticky status register and a maskable interrupt line. It occupies the same position on the shared tri-state data bus as the single-port I/O block it replaces.

## Interface
- DATA_WIDTH, 4, width of each port and of the data bus
- ADDR_WIDTH, 11, data address width
- NUM_PORTS, 2, number of input ports and of output ports; must satisfy 1 ≤ NUM_PORTS ≤ DATA_WIDTH
- BASE_ADDR, 11'h7FA, first address of the window; the window is 2·NUM_PORTS+2 words

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- write_en  in  1  bus write strobe
- read_en  in  1  bus read strobe
- in_addr  in  ADDR_WIDTH  bus address
- in_data  in  DATA_WIDTH  bus write data
- out_data  out  DATA_WIDTH  bus read data; high-Z unless a read hits the window
- in_ports  in  NUM_PORTS·DATA_WIDTH  external input pins; port i occupies bits [i·DW +: DW]
- out_ports  out  NUM_PORTS·DATA_WIDTH  external output pins, same packing
- irq  out  1  interrupt request, level, active-high

## Operation
- Address map, as offset from BASE_ADDR:
  - 0..N-1: IN[i]. Read-only; returns the synchronized value. Writes are ignored.
  - N..2N-1: OUT[i]. Read/write; drives out_ports slice i.
  - 2N: STATUS. Bit i is set when input i changes. Read returns the bits zero-extended. A write clears every bit whose in_data bit is 1 (W1C).
  - 2N+1: MASK. Read/write; only bits [N-1:0] are stored. Read returns the value zero-extended.
- Synchronizer, per port, each stage DATA_WIDTH wide: s1 <= pin; s2 <= s1. IN[i] reads s2[i].
- Change detect: at each edge, if s1[i] ≠ s2[i] (pre-edge values), set STATUS[i].
  - If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
- irq = |(STATUS & MASK), combinational from registers. No glitch from bus inputs.
- out_data = selected register when read_en=1 and in_addr lies in the window; otherwise 'bz.
  - Reads are combinational and have no side effects.
- A write to an address outside the window, or to an IN address, changes no state.

## Timing
- Reset (async, immediate): s1, s2, OUT[*], STATUS and MASK clear to 0. out_ports=0, irq=0.
  - out_data is 'bz unless a read is active; during reset, reads return 0 for all registers.
- Reset asserted mid-operation: all of the above clear without waiting for an edge. Reset dominates write_en.
- After reset release with nonzero pins, STATUS[i] sets at the 2nd edge: s2 goes 0→pin, which counts as a change.
- Pin change settling before edge k:
  - s1 updates at edge k.
  - IN[i] and STATUS[i] update at edge k+1, giving 2-cycle input latency.
  - irq rises after edge k+1 if MASK[i]=1.
- Pin pulses shorter than one clock may be missed; this is not required behaviour.
- Write to OUT/MASK/STATUS takes effect at the edge where write_en=1.
  - out_ports and irq reflect the write in the following cycle.
- Read and write to the same address in the same cycle: out_data returns the pre-edge value.
- MASK write: irq follows combinationally after that edge. Clearing MASK does not clear STATUS.

## Test plan
- Reset: drive in_ports=8'hA5 and rst=1 → out_ports=0, irq=0, reads of all 6 addresses return 0. After release, STATUS reads 4'b0011 after 2 edges.
- Output write/readback: write 4'h9 to 2044 and 4'h3 to 2045 → out_ports=8'h39 next cycle. Reads return 9 and 3. A write to 2042 leaves all state unchanged.
- Input sync and latency: change port 0 from 0 to 4'h6 mid-cycle before edge k → read 2042 returns 0 through edge k and 6 after edge k+1. STATUS=4'b0001 after edge k+1.
- Interrupt: MASK=4'b0010, toggle port 0 → irq stays 0. Toggle port 1 → irq=1 after 2 edges. Write 4'b0010 to 2046 → irq=0 next cycle, STATUS=4'b0001.
- Set-vs-clear collision: W1C of STATUS bit 1 in the same cycle port 1's s1≠s2 → STATUS[1] remains 1.
- Bus idle/out-of-window: read_en=1 with in_addr=2041, or read_en=0 with in_addr=2044 → out_data='bz. Mid-operation async rst pulse clears OUT and STATUS before the next edge.

Source files
------------

// File: rtl/io_port_bank_if.sv
// Register-bus side of the I/O port bank: strobes, address and write data.
// The read-data return stays a plain tri-state net owned by the top level.
interface io_port_bank_if #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 11
);
   logic                  write_en;
   logic                  read_en;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;

   modport master (output write_en, read_en, in_addr, in_data);
   modport slave  (input  write_en, read_en, in_addr, in_data);
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS synchronized inputs and NUM_PORTS outputs with sticky change status and maskable irq.
// Reads are combinational (tri-state when not selected); writes land at the strobed edge; inputs have 2-cycle latency.
module io_port_bank #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 11,
   parameter int NUM_PORTS  = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 11'h7FA
) (
   input  logic                            clk,
   input  logic                            rst,
   io_port_bank_if.slave                   bus,
   output tri   [DATA_WIDTH-1:0]           out_data,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_ports,
   output logic [NUM_PORTS*DATA_WIDTH-1:0] out_ports,
   output logic                            irq
);
   localparam int N  = NUM_PORTS;
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] OFF_STATUS = (AW+1)'(2*N);
   localparam logic [AW:0] OFF_MASK   = (AW+1)'(2*N + 1);
   localparam logic [AW:0] WIN_WORDS  = (AW+1)'(2*N + 2);

   logic [N*DW-1:0] s1;
   logic [N*DW-1:0] s2;
   logic [N*DW-1:0] out_reg;
   logic [N-1:0]    status;
   logic [N-1:0]    mask;

   logic [AW:0]     rel;
   logic            hit;
   logic            wr;
   logic [N-1:0]    chg;
   logic [N-1:0]    clr;
   logic [DW-1:0]   rd_val;

   // One extra bit keeps the window test correct when the window ends at the top of the address space.
   assign rel = {1'b0, bus.in_addr} - {1'b0, BASE_ADDR};
   assign hit = (bus.in_addr >= BASE_ADDR) && (rel < WIN_WORDS);
   assign wr  = bus.write_en && hit;

   always_comb begin
      chg = '0;
      for (int i = 0; i < N; i++) begin
         chg[i] = (s1[i*DW +: DW] != s2[i*DW +: DW]);
      end
   end

   assign clr = (wr && rel == OFF_STATUS) ? bus.in_data[N-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= '0;
         s2      <= '0;
         out_reg <= '0;
         status  <= '0;
         mask    <= '0;
      end else begin
         s1     <= in_ports;
         s2     <= s1;
         // A new change outranks a simultaneous W1C of the same bit.
         status <= (status & ~clr) | chg;
         if (wr && rel == OFF_MASK) begin
            mask <= bus.in_data[N-1:0];
         end
         for (int i = 0; i < N; i++) begin
            if (wr && rel == (AW+1)'(N + i)) begin
               out_reg[i*DW +: DW] <= bus.in_data;
            end
         end
      end
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < N; i++) begin
         if (rel == (AW+1)'(i)) begin
            rd_val = s2[i*DW +: DW];
         end
         if (rel == (AW+1)'(N + i)) begin
            rd_val = out_reg[i*DW +: DW];
         end
      end
      if (rel == OFF_STATUS) begin
         rd_val[N-1:0] = status;
      end
      if (rel == OFF_MASK) begin
         rd_val[N-1:0] = mask;
      end
   end

   assign out_data  = (bus.read_en && hit) ? rd_val : 'bz;
   assign out_ports = out_reg;
   assign irq       = |(status & mask);
endmodule
